// File: rtl/pal_cfg_loader.sv
// PAL configuration sequencer: takes bitstream bytes over valid/ready, shifts them LSB-first
// onto the PAL config line, then holds the apply strobe before signalling completion.
module pal_cfg_loader #(
  parameter int unsigned CFG_LEN      = 280,
  parameter int unsigned APPLY_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       CFG_BIT,
  output logic       CFG_SHIFT,
  output logic       CFG_APPLY,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned CntW = $clog2(CFG_LEN + 1);
  localparam int unsigned AppW = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] LenMax = CntW'(CFG_LEN);
  localparam logic [AppW-1:0] AppMax = AppW'(APPLY_CYCLES);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StApply, StFin} state_e;

  state_e          r_state;
  logic [6:0]      r_sreg;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_bit_idx;
  logic [AppW-1:0] r_app_cnt;
  logic            r_cfg_bit;
  logic            r_cfg_shift;
  logic            r_cfg_apply;
  logic            r_busy;
  logic            r_done;

  // r_cnt and r_bit_idx count the bit currently presented on CFG_BIT
  logic w_byte_end;
  assign w_byte_end = (r_bit_idx == 4'd8) || (r_cnt == LenMax);

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_state     <= StIdle;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_app_cnt   <= '0;
      r_cfg_bit   <= 1'b0;
      r_cfg_shift <= 1'b0;
      r_cfg_apply <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ABORT && (r_state inside {StLoad, StShift, StApply})) begin
        r_state     <= StIdle;
        r_cfg_shift <= 1'b0;
        r_cfg_apply <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (START) begin
              r_state <= StLoad;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          StLoad: begin
            // Bit 0 goes out in the first SHIFT cycle, so only bits 7:1 are kept
            if (DATA_VALID) begin
              r_state     <= StShift;
              r_sreg      <= DATA_IN[7:1];
              r_cfg_bit   <= DATA_IN[0];
              r_cfg_shift <= 1'b1;
              r_cnt       <= r_cnt + 1'b1;
              r_bit_idx   <= 4'd1;
            end
          end
          StShift: begin
            if (w_byte_end) begin
              r_cfg_shift <= 1'b0;
              if (r_cnt == LenMax) begin
                r_state     <= StApply;
                r_cfg_apply <= 1'b1;
                r_app_cnt   <= AppW'(1);
              end else begin
                r_state <= StLoad;
              end
            end else begin
              r_cfg_bit <= r_sreg[0];
              r_sreg    <= {1'b0, r_sreg[6:1]};
              r_cnt     <= r_cnt + 1'b1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
          StApply: begin
            if (r_app_cnt == AppMax) begin
              r_state     <= StFin;
              r_cfg_apply <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_app_cnt <= r_app_cnt + 1'b1;
            end
          end
          StFin: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DATA_READY = (r_state == StLoad);
  assign CFG_BIT    = r_cfg_bit;
  assign CFG_SHIFT  = r_cfg_shift;
  assign CFG_APPLY  = r_cfg_apply;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: two instances (280-bit and 12-bit chains) compared every cycle
// against a queue-based model of the bit stream, plus literal checks on counts and timing.
module tb_pal_cfg_loader;

  localparam int PhIdle  = 0;
  localparam int PhWait  = 1;
  localparam int PhShift = 2;
  localparam int PhApply = 3;
  localparam int PhDone  = 4;
  localparam int ApplyCycles = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start  [2];
  logic       abort_i[2];
  logic       valid  [2];
  logic [7:0] data   [2];
  logic       ready  [2];
  logic       cbit   [2];
  logic       cshift [2];
  logic       capply [2];
  logic       busy   [2];
  logic       done   [2];

  always #5 clk = ~clk;

  pal_cfg_loader #(.CFG_LEN(280), .APPLY_CYCLES(ApplyCycles)) u_dut0 (
    .CLK(clk), .RES_N(rst_n), .START(start[0]), .ABORT(abort_i[0]), .DATA_IN(data[0]),
    .DATA_VALID(valid[0]), .DATA_READY(ready[0]), .CFG_BIT(cbit[0]), .CFG_SHIFT(cshift[0]),
    .CFG_APPLY(capply[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  pal_cfg_loader #(.CFG_LEN(12), .APPLY_CYCLES(ApplyCycles)) u_dut1 (
    .CLK(clk), .RES_N(rst_n), .START(start[1]), .ABORT(abort_i[1]), .DATA_IN(data[1]),
    .DATA_VALID(valid[1]), .DATA_READY(ready[1]), .CFG_BIT(cbit[1]), .CFG_SHIFT(cshift[1]),
    .CFG_APPLY(capply[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int len_of(input int k);
    return (k == 0) ? 280 : 12;
  endfunction

  // Model: accepted bytes become a queue of bits still to appear on CFG_BIT
  int m_phase   [2];
  bit m_q       [2][$];
  int m_total   [2];
  int m_app_left[2];
  bit m_cur     [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = PhIdle;
      m_q[k].delete();
      m_total[k] = 0;
      m_app_left[k] = 0;
      m_cur[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k);
    int n;
    bit aborting;
    aborting = abort_i[k] && (m_phase[k] inside {PhWait, PhShift, PhApply});
    if (aborting) begin
      m_phase[k] = PhIdle;
      m_q[k].delete();
    end else begin
      case (m_phase[k])
        PhIdle: if (start[k]) begin
          m_phase[k] = PhWait;
          m_total[k] = 0;
        end
        PhWait: if (valid[k]) begin
          n = len_of(k) - m_total[k];
          if (n > 8) n = 8;
          for (int i = 0; i < n; i++) m_q[k].push_back(data[k][i]);
          m_total[k] += n;
          m_cur[k] = m_q[k].pop_front();
          m_phase[k] = PhShift;
        end
        PhShift: begin
          if (m_q[k].size() > 0) m_cur[k] = m_q[k].pop_front();
          else if (m_total[k] == len_of(k)) begin
            m_phase[k] = PhApply;
            m_app_left[k] = ApplyCycles;
          end else m_phase[k] = PhWait;
        end
        PhApply: begin
          m_app_left[k]--;
          if (m_app_left[k] == 0) m_phase[k] = PhDone;
        end
        default: m_phase[k] = PhIdle;
      endcase
    end
  endfunction

  function automatic logic [5:0] exp_vec(input int k);
    return {m_phase[k] == PhWait, m_cur[k], m_phase[k] == PhShift, m_phase[k] == PhApply,
            m_phase[k] != PhIdle, m_phase[k] == PhDone};
  endfunction

  function automatic logic [5:0] act_vec(input int k);
    return {ready[k], cbit[k], cshift[k], capply[k], busy[k], done[k]};
  endfunction

  // Observed-activity counters, cleared per test
  int sh_cnt[2], ap_cnt[2], dn_cnt[2], busy_cyc[2], rdy_rise[2], ones[2];
  bit prev_rdy[2];
  bit bits0[$];

  task automatic clr_counters();
    for (int k = 0; k < 2; k++) begin
      sh_cnt[k] = 0; ap_cnt[k] = 0; dn_cnt[k] = 0;
      busy_cyc[k] = 0; rdy_rise[k] = 0; ones[k] = 0;
    end
    bits0.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        model_step(0);
        model_step(1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("outs_dut%0d {rdy,bit,shift,apply,busy,done}", k),
            int'(act_vec(k)), int'(exp_vec(k)));
        if (cshift[k]) begin
          sh_cnt[k]++;
          if (cbit[k]) ones[k]++;
          if (k == 0) bits0.push_back(cbit[k]);
        end
        if (capply[k]) ap_cnt[k]++;
        if (done[k]) dn_cnt[k]++;
        if (busy[k]) busy_cyc[k]++;
        if (ready[k] && !prev_rdy[k]) rdy_rise[k]++;
        prev_rdy[k] = ready[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input int mode, input int idx);
    case (mode)
      0: return 8'hA5;
      2: return (idx == 0) ? 8'hFF : (idx == 1) ? 8'h0F : 8'($urandom);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Feeds bytes until DONE is seen; vprob is the per-cycle VALID probability in percent
  task automatic drive_load(input int k, input int mode, input int vprob, input bit noise,
                            input int budget);
    int idx;
    bit hs, fin;
    idx = 0;
    fin = 1'b0;
    data[k] = pick(mode, 0);
    for (int c = 0; c < budget && !fin; c++) begin
      valid[k] = ($urandom_range(0, 99) < vprob);
      if (noise && busy[k] && !done[k] && $urandom_range(0, 7) == 0) start[k] = 1'b1;
      @(negedge clk);
      hs = ready[k] && valid[k] && !abort_i[k];
      fin = done[k];
      tick();
      start[k] = 1'b0;
      if (hs) begin
        idx++;
        data[k] = pick(mode, idx);
      end
    end
    valid[k] = 1'b0;
    chk($sformatf("load_completes_dut%0d", k), int'(fin), 1);
  endtask

  task automatic wait_shifts(input int k, input int n, input int budget);
    int c;
    c = 0;
    while (sh_cnt[k] < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_shifts_in_time", int'(sh_cnt[k] >= n), 1);
  endtask

  initial begin
    int errs, sh_before;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; abort_i[k] = 1'b0; valid[k] = 1'b0; data[k] = 8'h00;
      prev_rdy[k] = 1'b0;
    end
    model_reset();
    clr_counters();
    tick(); tick();
    chk("reset_outs_dut0", int'(act_vec(0)), 0);
    chk("reset_outs_dut1", int'(act_vec(1)), 0);
    rst_n = 1'b1;
    tick();

    // 1: 35 bytes of 0xA5, VALID always high (best case)
    clr_counters();
    pulse_start(0);
    drive_load(0, 0, 100, 1'b0, 1000);
    chk("t1_shift_pulses", sh_cnt[0], 280);
    chk("t1_apply_cycles", ap_cnt[0], 2);
    chk("t1_done_pulses", dn_cnt[0], 1);
    chk("t1_busy_cycles", busy_cyc[0], 35 + 280 + 2 + 1);
    chk("t1_busy_after", int'(busy[0]), 0);
    errs = 0;
    for (int i = 0; i < bits0.size(); i++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      if (bits0[i] !== pat[i % 8]) errs++;
    end
    chk("t1_a5_bit_errors", errs, 0);

    // 2 + 6: backpressure, random bytes, START noise while busy
    clr_counters();
    pulse_start(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_ready_held", int'(ready[0]), 1);
      chk("t2_no_shift", int'(cshift[0]), 0);
      tick();
    end
    drive_load(0, 1, 60, 1'b1, 3000);
    chk("t2_shift_pulses", sh_cnt[0], 280);
    chk("t2_done_pulses", dn_cnt[0], 1);
    chk("t2_apply_cycles", ap_cnt[0], 2);

    // 3: 12-bit chain, 0xFF then 0x0F
    clr_counters();
    pulse_start(1);
    drive_load(1, 2, 100, 1'b1, 200);
    valid[1] = 1'b1;
    repeat (3) tick();
    valid[1] = 1'b0;
    chk("t3_shift_pulses", sh_cnt[1], 12);
    chk("t3_ones", ones[1], 12);
    chk("t3_ready_rises", rdy_rise[1], 2);
    chk("t3_apply_cycles", ap_cnt[1], 2);
    chk("t3_done_pulses", dn_cnt[1], 1);

    // 4: ABORT during the third byte, then a full reload
    clr_counters();
    pulse_start(0);
    data[0] = 8'h3C;
    valid[0] = 1'b1;
    wait_shifts(0, 19, 100);
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    valid[0] = 1'b0;
    chk("t4_busy_after_abort", int'(busy[0]), 0);
    chk("t4_shift_after_abort", int'(cshift[0]), 0);
    repeat (5) tick();
    chk("t4_no_apply", ap_cnt[0], 0);
    chk("t4_no_done", dn_cnt[0], 0);
    clr_counters();
    pulse_start(0);
    drive_load(0, 1, 80, 1'b0, 3000);
    chk("t4_reload_shifts", sh_cnt[0], 280);
    chk("t4_reload_done", dn_cnt[0], 1);

    // 5: async reset mid-SHIFT
    clr_counters();
    pulse_start(0);
    data[0] = 8'($urandom);
    valid[0] = 1'b1;
    wait_shifts(0, 40, 200);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_reset_outs", int'(act_vec(0)), 0);
    tick();
    rst_n = 1'b1;
    sh_before = sh_cnt[0];
    repeat (5) tick();
    valid[0] = 1'b0;
    chk("t5_idle_without_start", int'(busy[0]), 0);
    chk("t5_no_shifts_after_reset", sh_cnt[0], sh_before);
    clr_counters();
    pulse_start(0);
    drive_load(0, 1, 70, 1'b1, 3000);
    chk("t5_reload_shifts", sh_cnt[0], 280);
    chk("t5_reload_done", dn_cnt[0], 1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
